pwm_audio_out: RTL and testbench
================================

Name: pwm_audio_out

Overview:
- Playback-side counterpart to the microphone capture path.
- Accepts signed 12-bit PCM samples over a valid/ready stream into a 16-entry FIFO.
- Releases one sample per sample period, which is the same clock-divided rate used for capture.
- Drives a single-bit PWM DAC pin (speaker/RC filter) with an offset-binary duty cycle, and flags underruns.

Parameters:
- SAMPLE_W, 12: sample width, two's complement.
- CLK_DIV, 40000: clk cycles per output sample; must be >= 2.
- PWM_BITS, 10: PWM resolution; PWM period is 2^PWM_BITS clk cycles; must be <= SAMPLE_W.
- FIFO_DEPTH, 16: sample FIFO entries; must be a power of two.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- in_sample  in  SAMPLE_W  signed PCM sample.
- in_valid  in  1  in_sample is valid.
- in_ready  out  1  FIFO can accept; equals !full, combinational from the FIFO count.
- enable  in  1  playback run/stop.
- pwm_out  out  1  registered PWM DAC output.
- sample_tick  out  1  one-cycle pulse at each sample-period boundary.
- underrun  out  1  one-cycle pulse when a tick finds the FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, async): all of the following are cleared.
  - FIFO pointers and count go to 0, so fifo_level=0 and in_ready=1.
  - tick_cnt=0, pwm_cnt=0.
  - cur_sample=0 and duty=2^(PWM_BITS-1), i.e. mid-scale.
  - pwm_out=0, sample_tick=0, underrun=0.
  - Reset mid-operation discards FIFO contents; no partial PWM period is completed.
- Push:
  - A push occurs when in_valid && in_ready; the sample is written at wr_ptr.
  - Push is independent of enable.
  - When full (count==FIFO_DEPTH), in_ready=0 and in_valid is ignored; no overwrite.
- Tick counter:
  - While enable=1, tick_cnt counts 0..CLK_DIV-1 and wraps.
  - sample_tick is registered and asserts the cycle after tick_cnt==CLK_DIV-1.
  - While enable=0, tick_cnt is held at 0 and sample_tick=0.
- Pop:
  - On the cycle sample_tick=1, if count>0 (evaluated that cycle), pop into cur_sample.
  - If count==0, cur_sample keeps its value and underrun pulses for exactly that cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Empty + push + tick in the same cycle: the pop does not see the new sample, underrun=1, count becomes 1.
- Full + tick: pop proceeds; in_ready rises the following cycle.
- Duty mapping (offset binary): duty = {~cur_sample[SAMPLE_W-1], cur_sample[SAMPLE_W-2 -: PWM_BITS-1]}.
  - 12'h800 maps to 0.
  - 12'h000 maps to 512.
  - 12'h7FF maps to 1023 (PWM_BITS=10).
- PWM:
  - pwm_cnt runs 0..2^PWM_BITS-1 free-running while enable=1, and is held at 0 while enable=0.
  - duty is reloaded from cur_sample only when pwm_cnt==2^PWM_BITS-1, so a PWM period is never changed mid-way.
  - pwm_out <= enable && (pwm_cnt < duty); output is registered, giving one cycle of latency from the compare.
  - Latency from pop to the new duty on the pin is at most 2^PWM_BITS+1 cycles.
- enable falling: pwm_out=0 on the next cycle; FIFO contents and cur_sample are retained.
- Pointer wrap: pointers are $clog2(FIFO_DEPTH) bits and wrap modulo the depth; the separate count disambiguates full from empty.

Decomposition:
- audio_pkg holds:
  - SAMPLE_W
  - typedef sample_t (logic signed [SAMPLE_W-1:0])
  - the default FIFO_DEPTH and CLK_DIV constants shared with the microphone capture path
- Sub-module sample_fifo (synchronous FIFO, async active-low reset):
  - Ports: push, pop, din, dout, count, full, empty.
  - pwm_audio_out contains the tick counter, the pop control and the PWM generator.

Test Plan (bench overrides CLK_DIV=32, PWM_BITS=4, FIFO_DEPTH=16):
- Reset, enable=1, no input -> every 32 cycles sample_tick=1 and underrun=1; pwm_out high 8 of every 16 cycles (mid-scale).
- Push 12'h7FF, then 12'h800, 12'h000 -> after successive ticks, duty 15/16, then 0/16, then 8/16; each change aligns to a PWM wrap, and fifo_level steps 3,2,1,0.
- Hold in_valid=1 with enable=0 and push 20 samples -> exactly 16 are accepted, in_ready=0 after the 16th, fifo_level=16; enable=1 -> FIFO drains in push order.
- Empty FIFO, in_valid pulse in the same cycle as sample_tick -> underrun=1, fifo_level=1; the next tick pops that sample with no underrun.
- Full FIFO with in_valid held, tick -> the pop occurs, in_ready=1 the next cycle, the push is accepted and level returns to 16.
- Assert rst=0 mid PWM-high phase with 5 entries queued -> pwm_out=0 and fifo_level=0 immediately (async); after release the output is mid-scale (8/16).

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample format and default rates/depths
// common to the capture and playback blocks.
package audio_pkg;

  localparam int unsigned SAMPLE_W           = 12;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 16;
  localparam int unsigned DEFAULT_CLK_DIV    = 40000;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with a separate occupancy count so that full and
// empty stay distinct when the power-of-two pointers wrap.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  sample_t                din,
  output sample_t                dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  sample_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == CNT_W'(0));
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pwm_audio_out.sv
// Playback path: buffers PCM samples, releases one per sample period and
// drives an offset-binary PWM DAC pin, flagging ticks that find no data.
module pwm_audio_out
  import audio_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int unsigned PWM_BITS   = 10,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  sample_t                     in_sample,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        enable,
  output logic                        pwm_out,
  output logic                        sample_tick,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TICK_W = $clog2(CLK_DIV);

  logic [TICK_W-1:0]   tick_cnt;
  logic                tick_last;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_last;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_nxt;
  sample_t             cur_sample;
  sample_t             fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [CNT_W-1:0]    count_nxt;
  logic                unused_sample_bits;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign pop       = sample_tick && !fifo_empty;
  assign tick_last = (tick_cnt == TICK_W'(CLK_DIV - 1));
  assign pwm_last  = &pwm_cnt;
  assign count_nxt = fifo_level + CNT_W'(push) - CNT_W'(pop);

  // Sign bit inverted gives offset binary; low sample bits below PWM
  // resolution are simply dropped.
  assign duty_nxt           = {~cur_sample[SAMPLE_W-1], cur_sample[SAMPLE_W-2 -: PWM_BITS-1]};
  assign unused_sample_bits = ^cur_sample;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_sample),
    .dout  (fifo_dout),
    .count (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sample-period timer; underrun is registered alongside the tick by
  // looking ahead at the occupancy the tick cycle will see.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      sample_tick <= enable && tick_last;
      underrun    <= enable && tick_last && (count_nxt == CNT_W'(0));
      if (!enable || tick_last) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_sample <= '0;
    end else if (pop) begin
      cur_sample <= fifo_dout;
    end
  end

  // Duty only changes at the end of a PWM period so no period is split.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt <= '0;
      duty    <= {1'b1, {(PWM_BITS-1){1'b0}}};
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= enable ? pwm_cnt + PWM_BITS'(1) : '0;
      if (pwm_last) begin
        duty <= duty_nxt;
      end
      pwm_out <= enable && (pwm_cnt < duty);
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Bench for pwm_audio_out: per-cycle comparison against a queue/arithmetic
// model plus directed scenarios with hand-computed expectations.
module tb_pwm_audio_out;
  import audio_pkg::*;

  localparam int CLK_DIV = 32;
  localparam int PWM_BITS = 4;
  localparam int DEPTH = 16;
  localparam int PWM_PER = 16;

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  sample_t in_sample = '0;
  logic    in_valid = 1'b0;
  logic    enable = 1'b0;
  logic    in_ready;
  logic    pwm_out;
  logic    sample_tick;
  logic    underrun;
  logic [4:0] fifo_level;

  int checks = 0;
  int errors = 0;

  pwm_audio_out #(
    .CLK_DIV    (CLK_DIV),
    .PWM_BITS   (PWM_BITS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_sample   (in_sample),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .enable      (enable),
    .pwm_out     (pwm_out),
    .sample_tick (sample_tick),
    .underrun    (underrun),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: FIFO as a queue, sample/PWM phase from the count of enabled cycles.
  sample_t mq[$];
  int      k;
  sample_t m_cur;
  int      m_duty;
  logic    m_tick, m_und, m_pwm;
  sample_t cur_before;
  int      phase;
  int      cnt_before;

  function automatic int duty_of(sample_t s);
    return (int'(s) + 2048) >> (SAMPLE_W - PWM_BITS);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      k = 0;
      m_cur = '0;
      m_duty = PWM_PER / 2;
      m_tick = 1'b0;
      m_und = 1'b0;
      m_pwm = 1'b0;
    end else begin
      cur_before = m_cur;
      phase = k % PWM_PER;
      cnt_before = mq.size();
      if (m_tick && mq.size() > 0) m_cur = mq.pop_front();
      if (in_valid && cnt_before < DEPTH) mq.push_back(in_sample);
      m_pwm = enable && (phase < m_duty);
      if (enable && phase == PWM_PER - 1) m_duty = duty_of(cur_before);
      m_tick = enable && (k % CLK_DIV == CLK_DIV - 1);
      m_und = m_tick && (mq.size() == 0);
      k = enable ? k + 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("pwm_out", 32'(pwm_out), 32'(m_pwm));
      check("sample_tick", 32'(sample_tick), 32'(m_tick));
      check("underrun", 32'(underrun), 32'(m_und));
      check("fifo_level", 32'(fifo_level), mq.size());
      check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    end
  end

  task automatic measure(input int n, output int ticks, output int unds, output int highs);
    ticks = 0;
    unds = 0;
    highs = 0;
    repeat (n) begin
      @(negedge clk);
      ticks += int'(sample_tick);
      unds += int'(underrun);
      highs += int'(pwm_out);
    end
  endtask

  task automatic wait_tick(output bit found);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sample_tick) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic push(input sample_t s);
    in_valid = 1'b1;
    in_sample = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    enable = 1'b0;
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, u, h, acc;
    bit found;
    int exp_hi[3];
    int exp_lv[3];
    exp_hi = '{15, 0, 8};
    exp_lv = '{2, 1, 0};

    // Reset values, then idle playback at mid-scale with underruns.
    repeat (2) @(posedge clk);
    #1;
    check("rst_pwm_out", 32'(pwm_out), 0);
    check("rst_fifo_level", 32'(fifo_level), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_sample_tick", 32'(sample_tick), 0);
    check("rst_underrun", 32'(underrun), 0);
    rst = 1'b1;
    enable = 1'b1;
    repeat (20) @(negedge clk);
    measure(128, t, u, h);
    check("idle_ticks", t, 4);
    check("idle_underruns", u, 4);
    check("idle_highs", h, 64);

    // Full-scale, zero-scale, mid-scale sequence.
    pulse_reset();
    push(sample_t'(12'h7FF));
    push(sample_t'(12'h800));
    push(sample_t'(12'h000));
    check("seq_level_3", 32'(fifo_level), 3);
    enable = 1'b1;
    wait_tick(found);
    check("seq_tick_seen", 32'(found), 1);
    check("seq_first_underrun", 32'(underrun), 0);
    for (int j = 0; j < 3; j++) begin
      repeat (16) @(negedge clk);
      check("seq_level", 32'(fifo_level), exp_lv[j]);
      measure(16, t, u, h);
      check("seq_highs", h, exp_hi[j]);
      check("seq_next_tick", 32'(sample_tick), 1);
      check("seq_next_underrun", 32'(underrun), (j == 2) ? 1 : 0);
    end

    // Fill past capacity with playback stopped.
    pulse_reset();
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      in_sample = sample_t'(i * 150 - 1400);
      @(negedge clk);
      acc += int'(in_ready);
      @(posedge clk);
      #1;
    end
    check("fill_accepted", acc, 16);
    check("fill_in_ready", 32'(in_ready), 0);
    check("fill_level", 32'(fifo_level), 16);

    // Full FIFO with in_valid held: tick frees one slot, refilled next cycle.
    enable = 1'b1;
    wait_tick(found);
    check("full_tick_seen", 32'(found), 1);
    check("full_tick_in_ready", 32'(in_ready), 0);
    check("full_tick_level", 32'(fifo_level), 16);
    @(negedge clk);
    check("full_after_in_ready", 32'(in_ready), 1);
    check("full_after_level", 32'(fifo_level), 15);
    @(negedge clk);
    check("full_refill_level", 32'(fifo_level), 16);
    in_valid = 1'b0;
    repeat (600) @(negedge clk);
    check("drain_level", 32'(fifo_level), 0);

    // Push landing on an empty FIFO in the tick cycle.
    wait_tick(found);
    check("empty_tick_seen", 32'(found), 1);
    check("empty_tick_underrun", 32'(underrun), 1);
    in_valid = 1'b1;
    in_sample = sample_t'(12'h400);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("empty_push_level", 32'(fifo_level), 1);
    wait_tick(found);
    check("late_tick_seen", 32'(found), 1);
    check("late_tick_underrun", 32'(underrun), 0);
    check("late_tick_level", 32'(fifo_level), 1);
    @(negedge clk);
    check("late_pop_level", 32'(fifo_level), 0);

    // Asynchronous reset during a PWM-high phase with data queued.
    pulse_reset();
    for (int i = 0; i < 5; i++) push(sample_t'(i * 300));
    check("arst_level_5", 32'(fifo_level), 5);
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pwm_out) begin
        found = 1'b1;
        break;
      end
    end
    check("arst_pwm_high_seen", 32'(found), 1);
    check("arst_level_before", 32'(fifo_level), 5);
    #2;
    rst = 1'b0;
    #1;
    check("arst_pwm_out", 32'(pwm_out), 0);
    check("arst_level", 32'(fifo_level), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    measure(16, t, u, h);
    check("arst_mid_highs", h, 8);
    check("arst_final_level", 32'(fifo_level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
